scene_mem_arbiter: RTL and testbench
====================================

Name: scene_mem_arbiter

Overview:
- Shares the dual-port scene memory (read port A, write port B; 300 cells of 2-bit block codes) among four requesters.
- Writers: scene generator and coin remover. Readers: scene drawer and collision detector.
- Grants are registered and held for bursts, with a burst limit against starvation.
- Returns read data with a 1-cycle valid strobe and forwards same-cycle write data to a colliding read.

Parameters:
ADDR_W, 9, scene cell address width
DATA_W, 2, cell code width (background/block/cactus/coin)
MAX_BURST, 300, max consecutive access cycles one holder keeps a port while the other requester of that port waits

Ports:
clk50M  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
gen_req  in  1  generator requests write port
gen_addr  in  ADDR_W  generator write address
gen_data  in  DATA_W  generator write data
gen_gnt  out  1  generator owns write port
rm_req  in  1  coin remover requests write port
rm_addr  in  ADDR_W  remover write address
rm_data  in  DATA_W  remover write data
rm_gnt  out  1  remover owns write port
drw_req  in  1  drawer requests read port
drw_addr  in  ADDR_W  drawer read address
drw_gnt  out  1  drawer owns read port
drw_rvalid  out  1  rdata valid for drawer
col_req  in  1  collision detector requests read port
col_addr  in  ADDR_W  collision read address
col_gnt  out  1  collision detector owns read port
col_rvalid  out  1  rdata valid for collision detector
rdata  out  DATA_W  read data for the requester flagged by rvalid
mem_raddr  out  ADDR_W  memory port A address
mem_waddr  out  ADDR_W  memory port B address
mem_we  out  1  memory port B write enable
mem_wdata  out  DATA_W  memory port B data
mem_rdata  in  DATA_W  memory port A data, 1-cycle synchronous latency

Behaviour:
- Reset (rst_n low, async): all gnt, rvalid and mem_we = 0; rdata = 0; burst counters = 0; read round-robin pointer = drawer, so the collision detector wins the first tie. Asserting reset mid-burst drops grants and pending rvalid immediately; nothing is written after reset asserts.
- Read port and write port arbitrate independently; one read and one write may proceed in the same cycle.
- Grant is registered. If a port is free and req=1 at edge N, gnt=1 from edge N+1. A requester never sees gnt without having requested.
- Access cycle = req & gnt both high.
  - Write access: mem_we=1, with mem_waddr/mem_wdata driven combinationally from the holder's addr/data.
  - Read access: mem_raddr driven combinationally from the holder's addr.
  - Outside access cycles: mem_we=0, and mem_waddr/mem_raddr/mem_wdata hold their last values.
- Release: holder drops req at edge N, so gnt=0 from N+1. The other requester, if pending, is granted at N+1 (no idle cycle). A released port and a new request in the same cycle are handled the same way.
- Write arbitration, free port: rm beats gen (fixed priority).
- Read arbitration, free port: single requester wins. On a tie, the requester that was not granted last wins (round-robin pointer updates on every grant).
- Burst limit:
  - A per-port counter increments each access cycle and clears on grant change. It saturates at MAX_BURST.
  - If the counter reaches MAX_BURST while the other requester of that port is pending, the holder's gnt drops at the next edge and the other requester is granted at that same edge.
  - If no one is waiting, the holder keeps the grant.
- Read return:
  - A read access at edge N yields rvalid=1 for exactly that requester during cycle N+1 (after edge N+1), with rdata = mem_rdata.
  - Forwarding: if that read access cycle also had mem_we=1 with mem_waddr == mem_raddr, rdata at N+1 is the registered mem_wdata instead of mem_rdata.
  - rvalid is independent of current gnt, so a final read is still returned after release.
- Invariants:
  - At most one of gen_gnt/rm_gnt is high; at most one of drw_gnt/col_gnt is high.
  - drw_rvalid and col_rvalid are never high together.
  - Addresses are passed through unchecked; the requester guarantees addr < 300.

Test Plan:
- Reset then gen_req=1 for 300 cycles writing addr k → code k%4 → gen_gnt rises 1 cycle after req; exactly 300 writes with mem_we=1 at addr 0..299; mem_we=0 afterwards.
- col_req and drw_req rise in the same cycle after reset → col_gnt first. After col releases, drw_gnt with no idle cycle. Next tie → col wins again (pointer = drawer).
- gen holding the write port with rm_req pending and MAX_BURST=4 → gen_gnt drops after 4 access cycles; rm_gnt rises at that same edge. gen is re-granted after rm releases.
- rm writes code 0 to addr 57 in the same cycle col reads addr 57 (memory holds 3) → col_rvalid next cycle with rdata=0 (forwarded). The same read without a write returns 3.
- Drawer burst reads addr 0..9 → drw_rvalid high 10 consecutive cycles, each lagging its address by 1 cycle. col_rvalid stays 0 throughout.
- rst_n pulled low mid-generator burst (addr 120) → all gnt/rvalid/mem_we go 0 asynchronously. After release, gen_req re-grants in 1 cycle with burst counter 0.

Source files
------------

// File: rtl/scene_mem_arbiter_if.sv
// scene_mem_arbiter_if: scene memory bus; slave = arbiter (gen/rm write reqs, drw/col read reqs, gnt/rvalid/rdata out, mem port A/B out, mem_rdata in), master = requesters plus memory
interface scene_mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 2
);
  logic              gen_req, rm_req, drw_req, col_req;
  logic [ADDR_W-1:0] gen_addr, rm_addr, drw_addr, col_addr;
  logic [DATA_W-1:0] gen_data, rm_data;
  logic              gen_gnt, rm_gnt, drw_gnt, col_gnt;
  logic              drw_rvalid, col_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  gen_req, gen_addr, gen_data, rm_req, rm_addr, rm_data,
    input  drw_req, drw_addr, col_req, col_addr, mem_rdata,
    output gen_gnt, rm_gnt, drw_gnt, col_gnt, drw_rvalid, col_rvalid, rdata,
    output mem_raddr, mem_waddr, mem_we, mem_wdata
  );
  modport master (
    output gen_req, gen_addr, gen_data, rm_req, rm_addr, rm_data,
    output drw_req, drw_addr, col_req, col_addr, mem_rdata,
    input  gen_gnt, rm_gnt, drw_gnt, col_gnt, drw_rvalid, col_rvalid, rdata,
    input  mem_raddr, mem_waddr, mem_we, mem_wdata
  );
endinterface

// File: rtl/scene_mem_arbiter.sv
// scene_mem_arbiter: shares scene memory read port (drw/col, round-robin) and write port (rm over gen) with registered burst grants; ports clk50M, rst_n (async low), bus (scene_mem_arbiter_if.slave)
module scene_mem_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 2,
  parameter int MAX_BURST = 300
) (
  input logic                  clk50M,
  input logic                  rst_n,
  scene_mem_arbiter_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  logic              gen_gnt_q, gen_gnt_d, rm_gnt_q, rm_gnt_d;
  logic              drw_gnt_q, drw_gnt_d, col_gnt_q, col_gnt_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d, wcnt_inc, rcnt_inc;
  logic              drw_rv_q, drw_rv_d, col_rv_q, col_rv_d, fwd_q, fwd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic              gen_acc, rm_acc, drw_acc, col_acc, w_lim, r_lim;
  logic              gen_hold, rm_hold, drw_hold, col_hold;
  always_comb begin
    gen_acc    = gen_gnt_q & bus.gen_req;
    rm_acc     = rm_gnt_q & bus.rm_req;
    drw_acc    = drw_gnt_q & bus.drw_req;
    col_acc    = col_gnt_q & bus.col_req;
    wcnt_inc   = (gen_acc | rm_acc) && wcnt_q != CNT_MAX ? wcnt_q + 1'b1 : wcnt_q;
    rcnt_inc   = (drw_acc | col_acc) && rcnt_q != CNT_MAX ? rcnt_q + 1'b1 : rcnt_q;
    w_lim      = wcnt_inc == CNT_MAX;
    r_lim      = rcnt_inc == CNT_MAX;
    gen_hold   = gen_acc & ~(w_lim & bus.rm_req);
    rm_hold    = rm_acc & ~(w_lim & bus.gen_req);
    drw_hold   = drw_acc & ~(r_lim & bus.col_req);
    col_hold   = col_acc & ~(r_lim & bus.drw_req);
    gen_gnt_d  = gen_hold | (~rm_hold & ~gen_gnt_q & bus.gen_req & ~(bus.rm_req & ~rm_gnt_q));
    rm_gnt_d   = rm_hold | (~gen_hold & ~rm_gnt_q & bus.rm_req);
    drw_gnt_d  = drw_hold | (~col_hold & ~drw_gnt_q & bus.drw_req & ~(bus.col_req & ~col_gnt_q & ~ptr_q));
    col_gnt_d  = col_hold | (~drw_hold & ~col_gnt_q & bus.col_req & ~(bus.drw_req & ~drw_gnt_q & ptr_q));
    ptr_d      = col_gnt_d & ~col_gnt_q ? 1'b1 : drw_gnt_d & ~drw_gnt_q ? 1'b0 : ptr_q;
    wcnt_d     = {gen_gnt_d, rm_gnt_d} != {gen_gnt_q, rm_gnt_q} ? '0 : wcnt_inc;
    rcnt_d     = {drw_gnt_d, col_gnt_d} != {drw_gnt_q, col_gnt_q} ? '0 : rcnt_inc;
    waddr_d    = gen_acc ? bus.gen_addr : rm_acc ? bus.rm_addr : waddr_q;
    wdata_d    = gen_acc ? bus.gen_data : rm_acc ? bus.rm_data : wdata_q;
    raddr_d    = drw_acc ? bus.drw_addr : col_acc ? bus.col_addr : raddr_q;
    drw_rv_d   = drw_acc;
    col_rv_d   = col_acc;
    fwd_d      = (drw_acc | col_acc) & (gen_acc | rm_acc) & (waddr_d == raddr_d);
    fwd_data_d = wdata_d;
  end
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      gen_gnt_q  <= 1'b0;
      rm_gnt_q   <= 1'b0;
      drw_gnt_q  <= 1'b0;
      col_gnt_q  <= 1'b0;
      ptr_q      <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      drw_rv_q   <= 1'b0;
      col_rv_q   <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      gen_gnt_q  <= gen_gnt_d;
      rm_gnt_q   <= rm_gnt_d;
      drw_gnt_q  <= drw_gnt_d;
      col_gnt_q  <= col_gnt_d;
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      raddr_q    <= raddr_d;
      drw_rv_q   <= drw_rv_d;
      col_rv_q   <= col_rv_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
    end
  end
  assign bus.gen_gnt    = gen_gnt_q;
  assign bus.rm_gnt     = rm_gnt_q;
  assign bus.drw_gnt    = drw_gnt_q;
  assign bus.col_gnt    = col_gnt_q;
  assign bus.drw_rvalid = drw_rv_q;
  assign bus.col_rvalid = col_rv_q;
  assign bus.rdata      = fwd_q ? fwd_data_q : (drw_rv_q | col_rv_q) ? bus.mem_rdata : '0;
  assign bus.mem_we     = gen_acc | rm_acc;
  assign bus.mem_waddr  = waddr_d;
  assign bus.mem_wdata  = wdata_d;
  assign bus.mem_raddr  = raddr_d;
endmodule

// File: tb/tb_scene_mem_arbiter.sv
// tb_scene_mem_arbiter: table-driven grant vectors plus directed burst, forwarding and async-reset sequences
module tb_scene_mem_arbiter;
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [1:0] mem [512];
  scene_mem_arbiter_if #(.ADDR_W(9), .DATA_W(2)) bus ();
  scene_mem_arbiter #(.ADDR_W(9), .DATA_W(2), .MAX_BURST(4)) dut (
    .clk50M(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #10 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_raddr];
  end
  always @(posedge clk) if (bus.mem_we) wr_cnt <= wr_cnt + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [3:0] gnts;
    return {bus.gen_gnt, bus.rm_gnt, bus.drw_gnt, bus.col_gnt};
  endfunction
  function automatic logic [11:0] all_out;
    return {gnts(), bus.drw_rvalid, bus.col_rvalid, bus.mem_we, 3'b000, bus.rdata};
  endfunction
  initial begin
    vec_t vecs [12];
    int base, good;
    vecs = '{
      '{4'b1111, 4'b0101}, '{4'b1110, 4'b0110}, '{4'b1111, 4'b0110}, '{4'b1111, 4'b0110},
      '{4'b1111, 4'b1010}, '{4'b1111, 4'b1001}, '{4'b0101, 4'b0101}, '{4'b0000, 4'b0000},
      '{4'b1011, 4'b1010}, '{4'b1100, 4'b1000}, '{4'b0011, 4'b0001}, '{4'b0000, 4'b0000}
    };
    foreach (mem[i]) mem[i] = 2'(i % 4);
    {bus.gen_req, bus.rm_req, bus.drw_req, bus.col_req} = 4'b0000;
    bus.gen_addr = '0; bus.gen_data = '0; bus.rm_addr = '0; bus.rm_data = '0;
    bus.drw_addr = '0; bus.col_addr = '0;
    step;
    step;
    chk("reset_outputs", 32'(all_out()), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      {bus.gen_req, bus.rm_req, bus.drw_req, bus.col_req} = vecs[i].req;
      step;
      chk($sformatf("vec%0d_gnt", i), 32'(gnts()), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_rv_excl", i), 32'(bus.drw_rvalid & bus.col_rvalid), 0);
    end
    base = wr_cnt;
    good = 0;
    bus.gen_req = 1'b1;
    #1;
    chk("gen_gnt_not_yet", 32'(bus.gen_gnt), 0);
    step;
    chk("gen_gnt_rise", 32'(bus.gen_gnt), 1);
    for (int k = 0; k < 300; k++) begin
      bus.gen_addr = 9'(k);
      bus.gen_data = 2'(k % 4);
      #1;
      if (bus.mem_we && bus.mem_waddr == 9'(k) && bus.mem_wdata == 2'(k % 4)) good++;
      step;
    end
    bus.gen_req = 1'b0;
    #1;
    chk("burst_we_cycles", 32'(good), 300);
    chk("burst_write_count", 32'(wr_cnt - base), 300);
    chk("we_after_burst", 32'(bus.mem_we), 0);
    step;
    chk("gen_release", 32'(gnts()), 0);
    chk("we_idle", 32'(bus.mem_we), 0);
    bus.rm_req = 1'b1; bus.rm_addr = 9'd57; bus.rm_data = 2'd3;
    step;
    step;
    bus.rm_req = 1'b0;
    step;
    bus.col_req = 1'b1; bus.col_addr = 9'd57;
    step;
    chk("col_gnt", 32'(gnts()), 32'(4'b0001));
    step;
    bus.col_req = 1'b0;
    chk("plain_rvalid", 32'({bus.drw_rvalid, bus.col_rvalid}), 1);
    chk("plain_rdata", 32'(bus.rdata), 3);
    step;
    chk("rvalid_single", 32'(bus.col_rvalid), 0);
    bus.rm_req = 1'b1; bus.rm_addr = 9'd57; bus.rm_data = 2'd0;
    bus.col_req = 1'b1; bus.col_addr = 9'd57;
    step;
    #1;
    chk("fwd_both_gnt", 32'(gnts()), 32'(4'b0101));
    chk("fwd_write", 32'({bus.mem_we, bus.mem_waddr, bus.mem_raddr}), 32'({1'b1, 9'd57, 9'd57}));
    step;
    bus.rm_req = 1'b0; bus.col_req = 1'b0;
    chk("fwd_rvalid", 32'({bus.drw_rvalid, bus.col_rvalid}), 1);
    chk("fwd_mem_old", 32'(bus.mem_rdata), 3);
    chk("fwd_rdata", 32'(bus.rdata), 0);
    step;
    step;
    bus.drw_req = 1'b1;
    step;
    chk("drw_gnt", 32'(gnts()), 32'(4'b0010));
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) begin
        chk($sformatf("drw_rv%0d", k - 1), 32'({bus.drw_rvalid, bus.col_rvalid}), 2);
        chk($sformatf("drw_rd%0d", k - 1), 32'(bus.rdata), 32'((k - 1) % 4));
      end
      if (k < 10) bus.drw_addr = 9'(k);
      else bus.drw_req = 1'b0;
      step;
    end
    chk("drw_rv_end", 32'({bus.drw_rvalid, bus.col_rvalid}), 0);
    step;
    bus.gen_req = 1'b1; bus.gen_addr = '0; bus.gen_data = '0;
    bus.drw_req = 1'b1; bus.drw_addr = 9'd5;
    step;
    for (int k = 0; k <= 120; k++) begin
      bus.gen_addr = 9'(k);
      bus.gen_data = 2'(k % 4);
      if (k < 120) step;
    end
    #1;
    chk("pre_reset_active", 32'({bus.mem_we, bus.drw_rvalid, bus.gen_gnt, bus.mem_waddr}), 32'({3'b111, 9'd120}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(all_out()), 0);
    base = wr_cnt;
    bus.drw_req = 1'b0;
    step;
    step;
    chk("no_write_in_reset", 32'(wr_cnt - base), 0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_idle", 32'(gnts()), 0);
    step;
    chk("regrant", 32'(gnts()), 32'(4'b1000));
    bus.rm_req = 1'b1; bus.rm_addr = 9'd200;
    for (int j = 0; j < 3; j++) begin
      step;
      chk($sformatf("burst_hold%0d", j), 32'(gnts()), 32'(4'b1000));
    end
    step;
    chk("burst_handover", 32'(gnts()), 32'(4'b0100));
    bus.rm_req = 1'b0;
    step;
    chk("gen_regrant", 32'(gnts()), 32'(4'b1000));
    bus.gen_req = 1'b0;
    step;
    chk("final_idle", 32'(all_out()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
